pool_window_sequencer: RTL and testbench

POOL_WINDOW_SEQUENCER -- requirements
Module: pool_window_sequencer

---
 rtl/pool_window_sequencer.sv | 156 +++++++++++++++
 tb/tb_pool_window_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_sequencer.sv
// Sequences 2x2 pooling windows over a MAP_W x MAP_H feature map: fetches four samples,
// feeds them to an external pooling datapath, and writes one averaged result per window.
module pool_window_sequencer #(
   parameter int MAP_W  = 8,
   parameter int MAP_H  = 8,
   parameter int ADDR_W = 8,
   parameter int LAT    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic signed [7:0]        rd_data,
   output logic                     pool_clr,
   output logic                     pool_en,
   output logic signed [7:0]        pool_in,
   input  logic signed [7:0]        pool_avg,
   output logic                     wr_en,
   input  logic                     wr_ready,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic signed [7:0]        wr_data,
   output logic [ADDR_W-1:0]        win_cnt
);

   // state | meaning
   // IDLE  | waiting for start; done pulses here after the last window
   // CLEAR | pool_clr for one cycle to reset the pooling accumulator
   // FETCH | four reads of the 2x2 window, top row then bottom row
   // DRAIN | LAT+1 cycles for the last sample to pass through the datapath
   // WRITE | hold the result on the write port until wr_ready

   localparam int HALF_W = MAP_W / 2;
   localparam int HALF_H = MAP_H / 2;
   localparam int DW     = (LAT < 1) ? 1 : $clog2(LAT + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, WRITE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] col;
   logic [ADDR_W-1:0] rd_base;
   logic [ADDR_W-1:0] wr_base;
   logic [1:0]        fetch_cnt;
   logic [DW-1:0]     drain_cnt;
   logic              last_win;

   always_comb begin
      rd_base  = ADDR_W'(int'(row) * 2 * MAP_W + int'(col) * 2);
      wr_base  = ADDR_W'(int'(row) * HALF_W + int'(col));
      last_win = (row == ADDR_W'(HALF_H - 1)) && (col == ADDR_W'(HALF_W - 1));
   end

   // Read data lands the cycle after rd_en, the same cycle pool_en is high, so it is
   // forwarded directly, gated so the port reads zero whenever no sample is offered.
   assign pool_in = pool_en ? rd_data : 8'sd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         pool_clr  <= 1'b0;
         pool_en   <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         win_cnt   <= '0;
         row       <= '0;
         col       <= '0;
         fetch_cnt <= '0;
         drain_cnt <= '0;
      end else begin
         done     <= 1'b0;
         pool_clr <= 1'b0;
         pool_en  <= rd_en;
         if (abort && state != IDLE) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_en   <= 1'b0;
            pool_en <= 1'b0;
            wr_en   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= CLEAR;
                     busy     <= 1'b1;
                     pool_clr <= 1'b1;
                     row      <= '0;
                     col      <= '0;
                     win_cnt  <= '0;
                  end
               end
               CLEAR: begin
                  state     <= FETCH;
                  rd_en     <= 1'b1;
                  rd_addr   <= rd_base;
                  fetch_cnt <= 2'd3;
               end
               FETCH: begin
                  if (fetch_cnt == 2'd0) begin
                     state     <= DRAIN;
                     rd_en     <= 1'b0;
                     drain_cnt <= DW'(LAT);
                  end else begin
                     fetch_cnt <= fetch_cnt - 2'd1;
                     // second step jumps from the top-right sample to the next row
                     if (fetch_cnt == 2'd2)
                        rd_addr <= rd_addr + ADDR_W'(MAP_W - 1);
                     else
                        rd_addr <= rd_addr + 1'b1;
                  end
               end
               DRAIN: begin
                  if (drain_cnt == '0) begin
                     state   <= WRITE;
                     wr_en   <= 1'b1;
                     wr_addr <= wr_base;
                     wr_data <= pool_avg;
                  end else begin
                     drain_cnt <= drain_cnt - 1'b1;
                  end
               end
               WRITE: begin
                  if (wr_ready) begin
                     wr_en   <= 1'b0;
                     win_cnt <= win_cnt + 1'b1;
                     if (last_win) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state    <= CLEAR;
                        pool_clr <= 1'b1;
                        if (col == ADDR_W'(HALF_W - 1)) begin
                           col <= '0;
                           row <= row + 1'b1;
                        end else begin
                           col <= col + 1'b1;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Self-checking bench for pool_window_sequencer: memory and pooling datapath models,
// directed frames plus a random-memory frame compared against an arithmetic window model.
module tb_pool_window_sequencer;

   localparam int MAP_W  = 8;
   localparam int MAP_H  = 8;
   localparam int ADDR_W = 8;
   localparam int LAT    = 4;
   localparam int NWIN   = (MAP_W / 2) * (MAP_H / 2);
   localparam int FRAME  = NWIN * (LAT + 7);

   logic                     clk = 1'b0;
   logic                     rst, start, abort, wr_ready;
   logic                     busy, done, rd_en, pool_clr, pool_en, wr_en;
   logic [ADDR_W-1:0]        rd_addr, wr_addr, win_cnt;
   logic signed [7:0]        rd_data, pool_in, pool_avg, wr_data;

   always #5 clk = ~clk;

   pool_window_sequencer #(.MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .pool_clr(pool_clr), .pool_en(pool_en), .pool_in(pool_in), .pool_avg(pool_avg),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .win_cnt(win_cnt));

   // memory model: one-cycle read latency
   logic signed [7:0] mem [0:255];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   // pooling datapath model: running sum >>> 2, delayed LAT cycles
   int acc = 0;
   int nacc;
   logic signed [7:0] pipe [LAT];
   always_comb begin
      nacc = pool_clr ? 0 : acc;
      if (pool_en) nacc = nacc + int'(pool_in);
   end
   always @(posedge clk) begin
      acc <= nacc;
      pipe[0] <= 8'(nacc >>> 2);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign pool_avg = pipe[LAT-1];

   // monitors
   int rd_q[$];
   int wa_q[$];
   int wd_q[$];
   int tick = 0, n_pool_en = 0, n_pool_clr = 0, n_done = 0, stab_err = 0;
   logic pstall = 1'b0;
   logic [ADDR_W-1:0] pa;
   logic signed [7:0] pd;
   always @(posedge clk) begin
      tick <= tick + 1;
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (wr_en && wr_ready) begin
         wa_q.push_back(int'(wr_addr));
         wd_q.push_back(int'(wr_data));
      end
      if (pool_en) n_pool_en <= n_pool_en + 1;
      if (pool_clr) n_pool_clr <= n_pool_clr + 1;
      if (done) n_done <= n_done + 1;
      if (pstall && (!wr_en || wr_addr !== pa || wr_data !== pd)) stab_err <= stab_err + 1;
      pstall <= wr_en && !wr_ready && !abort && !rst;
      pa <= wr_addr;
      pd <= wr_data;
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // reference: window i covers rows 2r..2r+1, cols 2c..2c+1
   function automatic int win_base(input int i);
      return 2 * (i / (MAP_W / 2)) * MAP_W + 2 * (i % (MAP_W / 2));
   endfunction

   function automatic int exp_rd(input int k);
      int off[4];
      off = '{0, 1, MAP_W, MAP_W + 1};
      return (win_base(k / 4) + off[k % 4]) % 256;
   endfunction

   function automatic int exp_avg(input int i);
      int b, s;
      b = win_base(i);
      s = int'(mem[b]) + int'(mem[b+1]) + int'(mem[b+MAP_W]) + int'(mem[b+MAP_W+1]);
      return s >>> 2;
   endfunction

   task automatic frame_check(input string tag, input int ro, input int wo);
      int bad_rd, bad_wr;
      bad_rd = 0;
      bad_wr = 0;
      chk({tag, "_rd_count"}, rd_q.size() - ro, 4 * NWIN);
      chk({tag, "_wr_count"}, wa_q.size() - wo, NWIN);
      for (int k = 0; k < 4 * NWIN && ro + k < rd_q.size(); k++)
         if (rd_q[ro+k] != exp_rd(k)) bad_rd++;
      for (int i = 0; i < NWIN && wo + i < wa_q.size(); i++)
         if (wa_q[wo+i] != (i / (MAP_W / 2)) * (MAP_W / 2) + i % (MAP_W / 2) ||
             wd_q[wo+i] != exp_avg(i)) bad_wr++;
      chk({tag, "_rd_seq_errs"}, bad_rd, 0);
      chk({tag, "_wr_errs"}, bad_wr, 0);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      bit got;
      n = 0;
      got = 0;
      while (n < limit && !got) begin
         @(posedge clk);
         n++;
         #1;
         if (done) got = 1;
      end
      chk({tag, "_done_seen"}, int'(got), 1);
   endtask

   initial begin
      int ro, wo, t0, n, pe0, pc0, d0, se0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_win_cnt", int'(win_cnt), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // frame with address-valued memory
      ro = rd_q.size(); wo = wa_q.size();
      pulse_start();
      t0 = tick;
      wait_done("a", 2 * FRAME);
      chk("a_frame_cycles", tick - t0, FRAME);
      chk("a_win_cnt", int'(win_cnt), NWIN);
      chk("a_busy_on_done", int'(busy), 0);
      chk("a_rd0", rd_q[ro+0], 0);
      chk("a_rd1", rd_q[ro+1], 1);
      chk("a_rd2", rd_q[ro+2], 8);
      chk("a_rd3", rd_q[ro+3], 9);
      chk("a_rd4", rd_q[ro+4], 2);
      chk("a_rd7", rd_q[ro+7], 11);
      chk("a_wr0_addr", wa_q[wo+0], 0);
      chk("a_wr0_data", wd_q[wo+0], 4);
      chk("a_wr1_addr", wa_q[wo+1], 1);
      chk("a_wr1_data", wd_q[wo+1], 6);
      frame_check("a", ro, wo);
      @(posedge clk); #1;
      chk("a_done_one_cycle", int'(done), 0);

      // constant negative memory
      for (int i = 0; i < 256; i++) mem[i] = -8'sd8;
      ro = rd_q.size(); wo = wa_q.size(); pe0 = n_pool_en; pc0 = n_pool_clr;
      pulse_start();
      wait_done("b", 2 * FRAME);
      #1;
      chk("b_pool_en_count", n_pool_en - pe0, 4 * NWIN);
      chk("b_pool_clr_count", n_pool_clr - pc0, NWIN);
      chk("b_wr5_data", wd_q[wo+5], -8);
      frame_check("b", ro, wo);

      // random memory, write stall on window 3
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      ro = rd_q.size(); wo = wa_q.size(); se0 = stab_err;
      pulse_start();
      t0 = tick;
      n = 0;
      while (win_cnt != 3 && n < 500) begin @(negedge clk); n++; end
      chk("c_reach_win3", int'(n < 500), 1);
      wr_ready = 1'b0;
      n = 0;
      while (!wr_en && n < 100) begin @(negedge clk); n++; end
      chk("c_reach_write", int'(n < 100), 1);
      chk("c_stall_addr", int'(wr_addr), 3);
      repeat (4) @(negedge clk);
      chk("c_stall_wr_en", int'(wr_en), 1);
      chk("c_stall_addr_held", int'(wr_addr), 3);
      chk("c_stall_data_held", int'(wr_data), exp_avg(3));
      chk("c_stall_win_cnt", int'(win_cnt), 3);
      @(negedge clk) wr_ready = 1'b1;
      wait_done("c", 2 * FRAME);
      chk("c_frame_cycles", tick - t0, FRAME + 5);
      chk("c_win_cnt", int'(win_cnt), NWIN);
      chk("c_stability_errs", stab_err - se0, 0);
      frame_check("c", ro, wo);

      // abort during window 5 fetch, with a simultaneous start
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      pulse_start();
      n = 0;
      while (!(win_cnt == 5 && rd_en) && n < 500) begin @(negedge clk); n++; end
      chk("d_reach_fetch5", int'(n < 500), 1);
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk("d_busy", int'(busy), 0);
      chk("d_rd_en", int'(rd_en), 0);
      chk("d_pool_en", int'(pool_en), 0);
      chk("d_wr_en", int'(wr_en), 0);
      chk("d_done", int'(done), 0);
      @(negedge clk) begin abort = 1'b0; start = 1'b0; end
      ro = rd_q.size(); d0 = n_done;
      repeat (20) @(negedge clk);
      chk("d_no_reads", rd_q.size() - ro, 0);
      chk("d_no_done", n_done - d0, 0);
      chk("d_win_cnt_held", int'(win_cnt), 5);
      ro = rd_q.size(); wo = wa_q.size();
      pulse_start();
      wait_done("d_restart", 2 * FRAME);
      chk("d_restart_rd0", rd_q[ro], 0);
      frame_check("d", ro, wo);

      // start while busy, then reset in the middle of DRAIN
      ro = rd_q.size();
      pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (!(win_cnt == 1 && rd_en) && n < 500) begin @(negedge clk); n++; end
      chk("e_reach_fetch1", int'(n < 500), 1);
      n = 0;
      while (rd_en && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("e_busy", int'(busy), 0);
      chk("e_done", int'(done), 0);
      chk("e_rd_en", int'(rd_en), 0);
      chk("e_pool_clr", int'(pool_clr), 0);
      chk("e_pool_en", int'(pool_en), 0);
      chk("e_wr_en", int'(wr_en), 0);
      chk("e_rd_addr", int'(rd_addr), 0);
      chk("e_wr_addr", int'(wr_addr), 0);
      chk("e_wr_data", int'(wr_data), 0);
      chk("e_pool_in", int'(pool_in), 0);
      chk("e_win_cnt", int'(win_cnt), 0);
      n = 0;
      for (int k = 0; k < 8; k++) if (rd_q[ro+k] != exp_rd(k)) n++;
      chk("e_rd_seq_errs", n, 0);
      @(negedge clk) rst = 1'b0;
      ro = rd_q.size();
      repeat (20) @(negedge clk);
      chk("e_no_resume_busy", int'(busy), 0);
      chk("e_no_resume_rd", rd_q.size() - ro, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
